// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: parses UART command frames, strobes the ALU and streams its 16-bit result to the TX FIFO.
// Optional watchdog on the result wait is enabled by defining ALU_TIMEOUT_EN (adds the TIMEOUT parameter).
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CMD_OPER = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_NOOPER = 8'hDD
`ifdef ALU_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_rx_p_data,
  input  logic                    i_rx_d_vld,
  input  logic [2*DATA_WIDTH-1:0] i_alu_out,
  input  logic                    i_out_valid,
  input  logic                    i_fifo_full,
  output logic                    o_alu_en,
  output logic [3:0]              o_alu_fun,
  output logic [DATA_WIDTH-1:0]   o_op_a,
  output logic [DATA_WIDTH-1:0]   o_op_b,
  output logic [DATA_WIDTH-1:0]   o_tx_p_data,
  output logic                    o_tx_d_vld,
  output logic                    o_busy,
  output logic                    o_err
);
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LO, SEND_HI} state_t;
  state_t r_state, w_next;
  logic                    r_alu_en, w_alu_en;
  logic [3:0]              r_alu_fun, w_alu_fun;
  logic [DATA_WIDTH-1:0]   r_op_a, w_op_a, r_op_b, w_op_b, r_tx_data, w_tx_data;
  logic                    r_tx_vld, w_tx_vld, r_busy, w_busy, r_err, w_err;
  logic [2*DATA_WIDTH-1:0] r_res, w_res;
  logic                    w_send, w_expire;

`ifdef ALU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wd_cnt;
  // watchdog counts cycles spent in WAIT_RES, zero whenever outside it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_wd_cnt <= '0;
    else r_wd_cnt <= (r_state == WAIT_RES) ? r_wd_cnt + 1'b1 : '0;
  assign w_expire = r_state == WAIT_RES && !i_out_valid && r_wd_cnt == CW'(TIMEOUT - 1);
`else
  assign w_expire = 1'b0;
`endif

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // next-state decode; bytes arriving in busy states are simply not looked at
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (i_rx_d_vld) w_next = i_rx_p_data == CMD_OPER ? GET_A : i_rx_p_data == CMD_NOOPER ? GET_FUN : IDLE;
      GET_A:    if (i_rx_d_vld) w_next = GET_B;
      GET_B:    if (i_rx_d_vld) w_next = GET_FUN;
      GET_FUN:  if (i_rx_d_vld) w_next = ALU_RUN;
      ALU_RUN:  w_next = WAIT_RES;
      WAIT_RES: w_next = i_out_valid ? SEND_LO : w_expire ? IDLE : WAIT_RES;
      SEND_LO:  if (!i_fifo_full) w_next = SEND_HI;
      SEND_HI:  if (!i_fifo_full) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // next values of the registered outputs and the result holding register
  always_comb begin
    w_send    = (r_state == SEND_LO || r_state == SEND_HI) && !i_fifo_full;
    w_alu_en  = r_state == ALU_RUN;
    w_busy    = w_next inside {ALU_RUN, WAIT_RES, SEND_LO, SEND_HI};
    w_err     = w_expire || (r_state == IDLE && i_rx_d_vld && i_rx_p_data != CMD_OPER && i_rx_p_data != CMD_NOOPER);
    w_tx_vld  = w_send;
    w_tx_data = !w_send ? r_tx_data : r_state == SEND_LO ? r_res[DATA_WIDTH-1:0] : r_res[2*DATA_WIDTH-1:DATA_WIDTH];
    w_op_a    = (r_state == GET_A && i_rx_d_vld) ? i_rx_p_data : r_op_a;
    w_op_b    = (r_state == GET_B && i_rx_d_vld) ? i_rx_p_data : r_op_b;
    w_alu_fun = (r_state == GET_FUN && i_rx_d_vld) ? i_rx_p_data[3:0] : r_alu_fun;
    w_res     = (r_state == WAIT_RES && i_out_valid) ? i_alu_out : r_res;
  end

  // output registers; reset aborts any pending TX write at once
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_alu_en  <= 1'b0;
      r_alu_fun <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_res     <= '0;
    end else begin
      r_alu_en  <= w_alu_en;
      r_alu_fun <= w_alu_fun;
      r_op_a    <= w_op_a;
      r_op_b    <= w_op_b;
      r_tx_data <= w_tx_data;
      r_tx_vld  <= w_tx_vld;
      r_busy    <= w_busy;
      r_err     <= w_err;
      r_res     <= w_res;
    end

  assign o_alu_en    = r_alu_en;
  assign o_alu_fun   = r_alu_fun;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_tx_p_data = r_tx_data;
  assign o_tx_d_vld  = r_tx_vld;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and randomized command frames checked against a frame-level model.
module tb_alu_cmd_sequencer;
  localparam logic [7:0] CC = 8'hCC, DD = 8'hDD;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_vld = 1'b0, out_valid = 1'b0, fifo_full = 1'b0;
  logic [15:0] alu_out = '0;
  logic        o_alu_en, o_tx_d_vld, o_busy, o_err;
  logic [3:0]  o_alu_fun;
  logic [7:0]  o_op_a, o_op_b, o_tx_p_data;
  int          tests = 0, fails = 0;
  logic [7:0]  m_a = '0, m_b = '0, b;
  logic [3:0]  m_fun = '0;

  alu_cmd_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_p_data(rx_data), .i_rx_d_vld(rx_vld),
    .i_alu_out(alu_out), .i_out_valid(out_valid), .i_fifo_full(fifo_full),
    .o_alu_en(o_alu_en), .o_alu_fun(o_alu_fun), .o_op_a(o_op_a), .o_op_b(o_op_b),
    .o_tx_p_data(o_tx_p_data), .o_tx_d_vld(o_tx_d_vld), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero();
    chk("rst_alu_en", 16'(o_alu_en), 16'd0);
    chk("rst_alu_fun", 16'(o_alu_fun), 16'd0);
    chk("rst_op_a", 16'(o_op_a), 16'd0);
    chk("rst_op_b", 16'(o_op_b), 16'd0);
    chk("rst_tx_data", 16'(o_tx_p_data), 16'd0);
    chk("rst_tx_vld", 16'(o_tx_d_vld), 16'd0);
    chk("rst_busy", 16'(o_busy), 16'd0);
    chk("rst_err", 16'(o_err), 16'd0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    @(negedge clk);
    rx_vld = 1'b1;
    rx_data = v;
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic bad_byte(input logic [7:0] v);
    send_byte(v);
    chk("err_pulse", 16'(o_err), 16'd1);
    chk("err_busy", 16'(o_busy), 16'd0);
    @(negedge clk);
    chk("err_single", 16'(o_err), 16'd0);
  endtask

  task automatic stray_valid();
    @(negedge clk);
    out_valid = 1'b1;
    alu_out = 16'($urandom);
    @(negedge clk);
    out_valid = 1'b0;
    chk("stray_busy", 16'(o_busy), 16'd0);
    @(negedge clk);
    chk("stray_tx", 16'(o_tx_d_vld), 16'd0);
  endtask

  // one full command: frame in, ALU handshake, two TX bytes out with optional FIFO stalls
  task automatic do_cmd(input bit oper, input logic [7:0] a, input logic [7:0] bb, input logic [7:0] fun,
                        input logic [15:0] res, input int junk, input int slo, input int shi);
    logic [7:0] got[$];
    int first_c, rem;
    logic was_full;
    if (oper) begin
      send_byte(CC);
      chk("busy_get", 16'(o_busy), 16'd0);
      send_byte(a);
      send_byte(bb);
      m_a = a;
      m_b = bb;
    end else send_byte(DD);
    send_byte(fun);
    m_fun = fun[3:0];
    chk("en_early", 16'(o_alu_en), 16'd0);
    chk("busy_run", 16'(o_busy), 16'd1);
    @(negedge clk);
    chk("alu_en", 16'(o_alu_en), 16'd1);
    chk("alu_fun", 16'(o_alu_fun), 16'(m_fun));
    chk("op_a", 16'(o_op_a), 16'(m_a));
    chk("op_b", 16'(o_op_b), 16'(m_b));
    @(negedge clk);
    chk("alu_en_one", 16'(o_alu_en), 16'd0);
    for (int j = 0; j < junk; j++) begin
      send_byte(8'($urandom));
      chk("junk_err", 16'(o_err), 16'd0);
      chk("junk_op_a", 16'(o_op_a), 16'(m_a));
    end
    @(negedge clk);
    out_valid = 1'b1;
    alu_out = res;
    rem = slo;
    fifo_full = rem > 0;
    first_c = -1;
    for (int c = 0; c < 40 && got.size() < 2; c++) begin
      @(negedge clk);
      out_valid = 1'b0;
      was_full = fifo_full;
      if (was_full) chk("stall_no_write", 16'(o_tx_d_vld), 16'd0);
      if (was_full && got.size() == 1) chk("lo_held", 16'(o_tx_p_data), 16'(res[7:0]));
      if (o_tx_d_vld) begin
        if (got.size() == 0) first_c = c;
        got.push_back(o_tx_p_data);
      end
      if (o_tx_d_vld && got.size() == 1) rem = shi;
      else if (rem > 0) rem--;
      fifo_full = rem > 0;
    end
    fifo_full = 1'b0;
    chk("tx_count", 16'(got.size()), 16'd2);
    chk("tx_bytes", {(got.size() > 1) ? got[1] : 8'hxx, (got.size() > 0) ? got[0] : 8'hxx}, res);
    if (slo == 0) chk("tx_latency", 16'(first_c), 16'd1);
    chk("busy_done", 16'(o_busy), 16'd0);
    @(negedge clk);
    chk("tx_quiet", 16'(o_tx_d_vld), 16'd0);
    chk("err_quiet", 16'(o_err), 16'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero();
    rst_n = 1'b1;
    do_cmd(1'b0, 8'h00, 8'h00, 8'h13, 16'h1234, 0, 0, 0);
    do_cmd(1'b1, 8'h05, 8'h03, 8'h00, 16'h0008, 0, 0, 0);
    do_cmd(1'b0, 8'h00, 8'h00, 8'h01, 16'h0002, 0, 0, 0);
    bad_byte(8'h7A);
    do_cmd(1'b1, 8'hA5, 8'h5A, 8'hF6, 16'hBEEF, 0, 0, 0);
    do_cmd(1'b1, 8'h11, 8'h22, 8'h07, 16'hC3D4, 2, 6, 3);
    send_byte(CC);
    send_byte(8'h44);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero();
    m_a = '0;
    m_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(1'b0, 8'h00, 8'h00, 8'h0C, 16'h8001, 0, 0, 0);
    do_cmd(1'b1, 8'h9C, 8'h37, 8'h02, 16'h00FF, 1, 0, 0);
    for (int i = 0; i < 25; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k == 0) begin
        do b = 8'($urandom); while (b == CC || b == DD);
        bad_byte(b);
      end else if (k == 1) stray_valid();
      do_cmd($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
